instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 111 +++++++++++
 tb/tb_instr_encoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder feeding a 4-entry write FIFO into instruction memory.
// Define INSTR_ENCODER_JUMP_EN to enable j/jal (kinds 9/10); otherwise they are illegal.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  input  logic        load_base,
  input  logic [31:0] base_addr,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        err_illegal,
  output logic [15:0] words_written
);

  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  count_reg, count_next;
  logic        ready_reg, err_reg;
  logic [31:0] addr_reg;
  logic [15:0] written_reg;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept, push, pop;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req_kind)
      4'd0: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100000};
      4'd1: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100010};
      4'd2: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100100};
      4'd3: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100101};
      4'd4: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100110};
      4'd5: enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100111};
      4'd6: enc_word = {6'b100011, req_rs, req_rt, req_imm};
      4'd7: enc_word = {6'b101011, req_rs, req_rt, req_imm};
      4'd8: enc_word = {6'b001000, req_rs, req_rt, req_imm};
`ifdef INSTR_ENCODER_JUMP_EN
      4'd9:  enc_word = {6'b000010, req_target};
      4'd10: enc_word = {6'b000011, req_target};
`endif
      default: enc_legal = 1'b0;
    endcase
  end

`ifndef INSTR_ENCODER_JUMP_EN
  logic unused_target;
  assign unused_target = ^req_target;
`endif

  // Illegal kinds are still consumed so the requester never stalls on them.
  assign accept = req_valid & ready_reg;
  assign push   = accept & enc_legal;
  assign pop    = (count_reg != 3'd0) & imem_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ready_reg   <= 1'b1;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      written_reg <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= enc_word;
        wr_ptr_reg           <= wr_ptr_reg + 2'd1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 2'd1;
        written_reg <= written_reg + 16'd1;
      end
      count_reg <= count_next;
      // Ready reflects next-cycle occupancy, so a pop while full cannot open it early.
      ready_reg <= (count_next != 3'd4);
      err_reg   <= accept & ~enc_legal;
      if (load_base)
        addr_reg <= base_addr;
      else if (pop)
        addr_reg <= addr_reg + 32'd4;
    end
  end

  assign req_ready     = ready_reg;
  assign imem_we       = (count_reg != 3'd0);
  assign imem_wdata    = (count_reg != 3'd0) ? fifo_mem[rd_ptr_reg] : 32'd0;
  assign imem_addr     = addr_reg;
  assign err_illegal   = err_reg;
  assign words_written = written_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// against a transaction-level queue model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready;
  logic [3:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        load_base;
  logic [31:0] base_addr;
  logic        imem_we, imem_ready, err_illegal;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_written;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_ww;
  logic        m_err;

  instr_encoder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target), .load_base(load_base),
    .base_addr(base_addr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .err_illegal(err_illegal),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Returns {legal, word} computed from the instruction-format rules.
  function automatic logic [32:0] ref_encode(input logic [3:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    int funct_tbl [6] = '{32, 34, 36, 37, 38, 39};
    logic [31:0] w;
    logic jump_en;
`ifdef INSTR_ENCODER_JUMP_EN
    jump_en = 1'b1;
`else
    jump_en = 1'b0;
`endif
    w = 0;
    if (k <= 5) begin
      w = 32'(rs) * (2 ** 21) + 32'(rt) * (2 ** 16) + 32'(rd) * (2 ** 11) + 32'(funct_tbl[k]);
      return {1'b1, w};
    end
    if (k == 6) return {1'b1, 32'd35 * (2 ** 26) + 32'(rs) * (2 ** 21) + 32'(rt) * (2 ** 16) + 32'(imm)};
    if (k == 7) return {1'b1, 32'd43 * (2 ** 26) + 32'(rs) * (2 ** 21) + 32'(rt) * (2 ** 16) + 32'(imm)};
    if (k == 8) return {1'b1, 32'd8 * (2 ** 26) + 32'(rs) * (2 ** 21) + 32'(rt) * (2 ** 16) + 32'(imm)};
    if (jump_en && k == 9)  return {1'b1, 32'd2 * (2 ** 26) + 32'(tgt)};
    if (jump_en && k == 10) return {1'b1, 32'd3 * (2 ** 26) + 32'(tgt)};
    return {1'b0, 32'd0};
  endfunction

  // Advance one clock and update the model from the inputs that were applied.
  task automatic tick();
    logic acc, pop;
    logic [32:0] e;
    acc = req_valid && (m_q.size() < 4);
    pop = (m_q.size() > 0) && imem_ready;
    e = ref_encode(req_kind, req_rs, req_rt, req_rd, req_imm, req_target);
    @(posedge clk);
    #1;
    if (reset) begin
      m_q.delete();
      m_addr = 0;
      m_ww = 0;
      m_err = 0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_ww = m_ww + 16'd1;
      end
      if (load_base) m_addr = base_addr;
      else if (pop) m_addr = m_addr + 32'd4;
      if (acc && e[32]) m_q.push_back(e[31:0]);
      m_err = acc && !e[32];
    end
  endtask

  task automatic set_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    req_valid = 1'b1; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; load_base = 1'b0; imem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    apply_reset();
    n_cmp += 6;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", req_ready); end
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %0b want 0", imem_we); end
    if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    if (imem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    if (words_written !== 16'd0) begin n_bad++; $display("FAIL reset_ww got %0d want 0", words_written); end
    if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err_illegal); end
    $display("test_reset done");
  endtask

  task automatic test_rtype();
    apply_reset();
    imem_ready = 1'b1;
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    req_valid = 1'b0;
    n_cmp += 3;
    if (imem_we !== 1'b1) begin n_bad++; $display("FAIL rtype_we got %0b want 1", imem_we); end
    if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rtype_addr got %h want 00000000", imem_addr); end
    if (imem_wdata !== 32'h00221820) begin n_bad++; $display("FAIL rtype_wdata got %h want 00221820", imem_wdata); end
    tick();
    n_cmp += 3;
    if (words_written !== 16'd1) begin n_bad++; $display("FAIL rtype_ww got %0d want 1", words_written); end
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rtype_we_after got %0b want 0", imem_we); end
    if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL rtype_addr_after got %h want 00000004", imem_addr); end
    $display("test_rtype: wdata=%h", 32'h00221820);
  endtask

  task automatic test_itype();
    apply_reset();
    imem_ready = 1'b1;
    set_req(4'd6, 5'd4, 5'd5, 5'd31, 16'h0010, 26'h0);
    tick();
    set_req(4'd8, 5'd0, 5'd8, 5'd7, 16'hFFFF, 26'h0);
    n_cmp += 2;
    if (imem_wdata !== 32'h8C850010) begin n_bad++; $display("FAIL lw_wdata got %h want 8c850010", imem_wdata); end
    if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL lw_addr got %h want 0", imem_addr); end
    tick();
    req_valid = 1'b0;
    n_cmp += 2;
    if (imem_wdata !== 32'h2008FFFF) begin n_bad++; $display("FAIL addi_wdata got %h want 2008ffff", imem_wdata); end
    if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL addi_addr got %h want 4", imem_addr); end
    tick();
    $display("test_itype: lw then addi");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[$];
    logic [31:0] got[$];
    logic acc_now;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      logic [32:0] e;
      e = ref_encode(4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0, 26'h0);
      exp_w.push_back(e[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      set_req(4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0, 26'h0);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_%0d got %0b want 1", i, req_ready); end
      tick();
    end
    set_req(4'd4, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got %0b want 0", req_ready); end
    tick();
    imem_ready = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pop_full_ready got %0b want 0", req_ready); end
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (imem_we && imem_ready) got.push_back(imem_wdata);
      acc_now = req_valid && req_ready;
      tick();
      if (acc_now) req_valid = 1'b0;
    end
    n_cmp++;
    if (got.size() != 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_cmp++;
      if (got[i] !== exp_w[i]) begin n_bad++; $display("FAIL bp_order_%0d got %h want %h", i, got[i], exp_w[i]); end
    end
    $display("test_back_to_back: %0d words drained", got.size());
  endtask

  task automatic test_load_base_wrap();
    apply_reset();
    load_base = 1'b1; base_addr = 32'hFFFFFFFC;
    tick();
    load_base = 1'b0;
    imem_ready = 1'b1;
    n_cmp++;
    if (imem_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL lb_addr got %h want fffffffc", imem_addr); end
    set_req(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    tick();
    set_req(4'd2, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
    n_cmp += 2;
    if (imem_we !== 1'b1) begin n_bad++; $display("FAIL lb_we0 got %0b want 1", imem_we); end
    if (imem_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL lb_addr0 got %h want fffffffc", imem_addr); end
    tick();
    req_valid = 1'b0;
    n_cmp += 2;
    if (imem_we !== 1'b1) begin n_bad++; $display("FAIL lb_we1 got %0b want 1", imem_we); end
    if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL lb_wrap got %h want 00000000", imem_addr); end
    load_base = 1'b1; base_addr = 32'h100;
    tick();
    load_base = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL lb_wins got %h want 00000100", imem_addr); end
    $display("test_load_base_wrap done");
  endtask

  task automatic test_illegal();
    apply_reset();
    imem_ready = 1'b1;
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0);
    tick();
    req_valid = 1'b0;
    n_cmp += 2;
    if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_err got %0b want 1", err_illegal); end
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL ill_we got %0b want 0", imem_we); end
    tick();
    n_cmp += 2;
    if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_err_pulse got %0b want 0", err_illegal); end
    if (words_written !== 16'd0) begin n_bad++; $display("FAIL ill_ww got %0d want 0", words_written); end
    $display("test_illegal: kind 12");
  endtask

  task automatic test_jump();
    apply_reset();
    imem_ready = 1'b1;
    set_req(4'd9, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0000100);
    tick();
    req_valid = 1'b0;
    n_cmp += 2;
`ifdef INSTR_ENCODER_JUMP_EN
    if (imem_wdata !== 32'h08000100) begin n_bad++; $display("FAIL jump_wdata got %h want 08000100", imem_wdata); end
    if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL jump_err got %0b want 0", err_illegal); end
`else
    if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL jump_err got %0b want 1", err_illegal); end
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL jump_we got %0b want 0", imem_we); end
`endif
    tick();
    $display("test_jump: kind 9");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(4'd3, 5'(i), 5'(i), 5'(i), 16'h0, 26'h0);
      tick();
    end
    req_valid = 1'b0;
    n_cmp++;
    if (imem_we !== 1'b1) begin n_bad++; $display("FAIL rm_pending got %0b want 1", imem_we); end
    reset = 1'b1; imem_ready = 1'b1; load_base = 1'b1; base_addr = 32'h40;
    tick();
    reset = 1'b0; load_base = 1'b0;
    n_cmp += 3;
    if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rm_we got %0b want 0", imem_we); end
    if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rm_addr got %h want 0", imem_addr); end
    if (words_written !== 16'd0) begin n_bad++; $display("FAIL rm_ww got %0d want 0", words_written); end
    tick(); tick();
    n_cmp += 2;
    if (words_written !== 16'd0) begin n_bad++; $display("FAIL rm_ww_later got %0d want 0", words_written); end
    if (imem_wdata !== 32'd0) begin n_bad++; $display("FAIL rm_wdata got %h want 0", imem_wdata); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_kind   = 4'($urandom_range(0, 15));
      req_rs     = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
      req_imm    = 16'($urandom); req_target = 26'($urandom);
      imem_ready = ($urandom_range(0, 9) < 6);
      load_base  = ($urandom_range(0, 19) == 0);
      base_addr  = {$urandom} & 32'hFFFFFFFC;
      n_cmp += 6;
      if (req_ready !== (m_q.size() < 4)) begin n_bad++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, req_ready, m_q.size() < 4); end
      if (imem_we !== (m_q.size() > 0)) begin n_bad++; $display("FAIL rnd_we c=%0d got %0b want %0b", c, imem_we, m_q.size() > 0); end
      if (imem_wdata !== ((m_q.size() > 0) ? m_q[0] : 32'd0)) begin n_bad++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, imem_wdata, (m_q.size() > 0) ? m_q[0] : 32'd0); end
      if (imem_addr !== m_addr) begin n_bad++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_addr, m_addr); end
      if (words_written !== m_ww) begin n_bad++; $display("FAIL rnd_ww c=%0d got %0d want %0d", c, words_written, m_ww); end
      if (err_illegal !== m_err) begin n_bad++; $display("FAIL rnd_err c=%0d got %0b want %0b", c, err_illegal, m_err); end
      tick();
    end
    req_valid = 1'b0; load_base = 1'b0;
    $display("test_random: 400 cycles, %0d words written", m_ww);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_imm = '0; req_target = '0; load_base = 1'b0; base_addr = '0; imem_ready = 1'b0;
    m_addr = 0; m_ww = 0; m_err = 0;
    test_reset();
    test_rtype();
    test_itype();
    test_back_to_back();
    test_load_base_wrap();
    test_illegal();
    test_jump();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
